// File: rtl/cpu6_mtimer_pkg.sv
// cpu6_mtimer_pkg: register offsets, ctrl field positions and defaults shared by the machine timer.
package cpu6_mtimer_pkg;
  localparam int CPU6_XLEN = 32;
  localparam int CPU6_PRESC_W = 8;
  localparam logic [63:0] CPU6_TMR_CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [2:0] CPU6_TMR_MTIME_LO = 3'd0;
  localparam logic [2:0] CPU6_TMR_MTIME_HI = 3'd1;
  localparam logic [2:0] CPU6_TMR_CMP_LO = 3'd2;
  localparam logic [2:0] CPU6_TMR_CMP_HI = 3'd3;
  localparam logic [2:0] CPU6_TMR_CTRL = 3'd4;
  localparam int CPU6_TMR_CTRL_EN = 0;
  localparam int CPU6_TMR_CTRL_DIV_LSB = 1;
  typedef enum logic {TMR_IDLE, TMR_RESP} tmr_st_e;
  function automatic logic tmr_mapped(input logic [2:0] idx);
    return idx <= CPU6_TMR_CTRL;
  endfunction
endpackage

// File: rtl/cpu6_mtimer_presc.sv
// cpu6_mtimer_presc: prescaler counting 0..div, one tick on the cycle the count equals div.
module cpu6_mtimer_presc #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);
  logic [PRESC_W-1:0] cnt;
  assign tick = en && (cnt == div);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (clr || !en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/cpu6_mtimer.sv
// cpu6_mtimer: memory-mapped 64-bit machine timer with prescaler, compare and registered level interrupt.
module cpu6_mtimer
  import cpu6_mtimer_pkg::*;
#(
  parameter int          XLEN    = CPU6_XLEN,
  parameter int          PRESC_W = CPU6_PRESC_W,
  parameter logic [63:0] CMP_RST = CPU6_TMR_CMP_RST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tmr_req_valid,
  output logic            tmr_req_ready,
  input  logic            tmr_req_wr,
  input  logic [4:0]      tmr_req_addr,
  input  logic [XLEN-1:0] tmr_req_wdat,
  output logic            tmr_rsp_valid,
  input  logic            tmr_rsp_ready,
  output logic [XLEN-1:0] tmr_rsp_rdat,
  output logic            tmr_rsp_err,
  output logic            tmr_irq_r
);
  tmr_st_e st, st_nxt;
  logic [63:0] mtime, mtimecmp;
  logic [31:0] hi_snap;
  logic en;
  logic [PRESC_W-1:0] div;
  logic tick, accept, wr_acc, rd_acc;
  logic wr_lo, wr_hi, wr_clo, wr_chi, wr_ctrl;
  logic [2:0] idx;
  logic [XLEN-1:0] rd_mux;
  logic unused_addr;
  assign unused_addr = ^tmr_req_addr[1:0];
  assign idx = tmr_req_addr[4:2];
  assign tmr_req_ready = (st == TMR_IDLE);
  assign tmr_rsp_valid = (st == TMR_RESP);
  assign accept = tmr_req_valid && tmr_req_ready;
  assign wr_acc = accept && tmr_req_wr;
  assign rd_acc = accept && !tmr_req_wr;
  assign wr_lo = wr_acc && (idx == CPU6_TMR_MTIME_LO);
  assign wr_hi = wr_acc && (idx == CPU6_TMR_MTIME_HI);
  assign wr_clo = wr_acc && (idx == CPU6_TMR_CMP_LO);
  assign wr_chi = wr_acc && (idx == CPU6_TMR_CMP_HI);
  assign wr_ctrl = wr_acc && (idx == CPU6_TMR_CTRL);
  // mtime_hi reads return the half captured by the last mtime_lo read, giving a tear-free 64-bit pair
  always_comb begin
    rd_mux = '0;
    rd_mux = (idx == CPU6_TMR_MTIME_LO) ? XLEN'(mtime[31:0]) :
             (idx == CPU6_TMR_MTIME_HI) ? XLEN'(hi_snap) :
             (idx == CPU6_TMR_CMP_LO)   ? XLEN'(mtimecmp[31:0]) :
             (idx == CPU6_TMR_CMP_HI)   ? XLEN'(mtimecmp[63:32]) :
             (idx == CPU6_TMR_CTRL)     ? XLEN'({div, en}) : '0;
  end
  always_comb begin
    st_nxt = st;
    st_nxt = accept ? TMR_RESP : (tmr_rsp_valid && tmr_rsp_ready) ? TMR_IDLE : st;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) st <= TMR_IDLE;
    else st <= st_nxt;
  cpu6_mtimer_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (wr_ctrl),
    .div  (div),
    .tick (tick)
  );
  // a software write to either half suppresses that cycle's increment of the whole counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) mtime <= '0;
    else if (wr_lo || wr_hi) begin
      if (wr_lo) mtime[31:0] <= tmr_req_wdat[31:0];
      if (wr_hi) mtime[63:32] <= tmr_req_wdat[31:0];
    end else if (tick) mtime <= mtime + 64'd1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) mtimecmp <= CMP_RST;
    else begin
      if (wr_clo) mtimecmp[31:0] <= tmr_req_wdat[31:0];
      if (wr_chi) mtimecmp[63:32] <= tmr_req_wdat[31:0];
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      en <= 1'b0;
      div <= '0;
    end else if (wr_ctrl) begin
      en <= tmr_req_wdat[CPU6_TMR_CTRL_EN];
      div <= tmr_req_wdat[CPU6_TMR_CTRL_DIV_LSB +: PRESC_W];
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) hi_snap <= '0;
    else if (rd_acc && (idx == CPU6_TMR_MTIME_LO)) hi_snap <= mtime[63:32];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tmr_rsp_rdat <= '0;
      tmr_rsp_err <= 1'b0;
    end else if (accept) begin
      tmr_rsp_rdat <= tmr_req_wr ? '0 : rd_mux;
      tmr_rsp_err <= !tmr_mapped(idx);
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) tmr_irq_r <= 1'b0;
    else tmr_irq_r <= (mtime >= mtimecmp);
endmodule

// File: tb/tb_cpu6_mtimer.sv
// tb_cpu6_mtimer: directed stimulus with a per-cycle reference model plus hand-computed literal checks.
module tb_cpu6_mtimer;
  logic clk = 1'b0, reset = 1'b0;
  logic tmr_req_valid = 1'b0, tmr_req_wr = 1'b0, tmr_rsp_ready = 1'b1;
  logic [4:0] tmr_req_addr = '0;
  logic [31:0] tmr_req_wdat = '0;
  logic tmr_req_ready, tmr_rsp_valid, tmr_rsp_err, tmr_irq_r;
  logic [31:0] tmr_rsp_rdat;
  int total = 0, bad = 0, cyc = 0, acc_cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu6_mtimer dut (
    .clk(clk), .reset(reset),
    .tmr_req_valid(tmr_req_valid), .tmr_req_ready(tmr_req_ready), .tmr_req_wr(tmr_req_wr),
    .tmr_req_addr(tmr_req_addr), .tmr_req_wdat(tmr_req_wdat),
    .tmr_rsp_valid(tmr_rsp_valid), .tmr_rsp_ready(tmr_rsp_ready),
    .tmr_rsp_rdat(tmr_rsp_rdat), .tmr_rsp_err(tmr_rsp_err), .tmr_irq_r(tmr_irq_r)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: architectural state of the timer, advanced once per clock
  logic [63:0] m_time, m_cmp;
  logic [7:0] m_div, m_cnt;
  logic [31:0] m_snap, m_rdat;
  logic m_en, m_busy, m_err, m_irq;

  function automatic logic [31:0] mrd(input logic [2:0] ix);
    case (ix)
      3'd0: return m_time[31:0];
      3'd1: return m_snap;
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {23'd0, m_div, m_en};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_time <= '0; m_cmp <= '1; m_en <= 1'b0; m_div <= '0; m_cnt <= '0; m_snap <= '0;
      m_busy <= 1'b0; m_rdat <= '0; m_err <= 1'b0; m_irq <= 1'b0;
    end else begin : upd
      logic tk, acc, w;
      logic [2:0] ix;
      tk = m_en && (m_cnt == m_div);
      acc = !m_busy && tmr_req_valid;
      w = acc && tmr_req_wr;
      ix = tmr_req_addr[4:2];
      m_irq <= (m_time >= m_cmp);
      if (w && ix == 3'd0) m_time <= {m_time[63:32], tmr_req_wdat};
      else if (w && ix == 3'd1) m_time <= {tmr_req_wdat, m_time[31:0]};
      else if (tk) m_time <= m_time + 64'd1;
      m_cnt <= ((w && ix == 3'd4) || !m_en || tk) ? 8'd0 : m_cnt + 8'd1;
      if (w && ix == 3'd2) m_cmp[31:0] <= tmr_req_wdat;
      if (w && ix == 3'd3) m_cmp[63:32] <= tmr_req_wdat;
      if (w && ix == 3'd4) begin
        m_en <= tmr_req_wdat[0];
        m_div <= tmr_req_wdat[8:1];
      end
      if (acc && !tmr_req_wr && ix == 3'd0) m_snap <= m_time[63:32];
      if (acc) begin
        m_busy <= 1'b1;
        m_rdat <= tmr_req_wr ? 32'd0 : mrd(ix);
        m_err <= (ix > 3'd4);
      end else if (m_busy && tmr_rsp_ready) m_busy <= 1'b0;
    end
  end

  always @(negedge clk)
    if (reset) begin
      chk("irq", tmr_irq_r, m_irq);
      chk("req_ready", tmr_req_ready, !m_busy);
      chk("rsp_valid", tmr_rsp_valid, m_busy);
      if (m_busy) begin
        chk("rsp_rdat", tmr_rsp_rdat, m_rdat);
        chk("rsp_err", tmr_rsp_err, m_err);
      end
    end

  task automatic bus(input logic wr, input logic [4:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er);
    int n = 0;
    tmr_req_valid = 1'b1; tmr_req_wr = wr; tmr_req_addr = a; tmr_req_wdat = d;
    while (!tmr_req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) chk("bus_timeout", 64'(n), 0);
    @(posedge clk); #1;
    acc_cyc = cyc;
    tmr_req_valid = 1'b0;
    rd = tmr_rsp_rdat; er = tmr_rsp_err;
    chk("bus_rsp_valid", tmr_rsp_valid, 1);
    @(posedge clk); #1;
  endtask

  logic [31:0] r;
  logic e;
  initial begin
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    chk("rst_irq", tmr_irq_r, 0);
    chk("rst_ready", tmr_req_ready, 1);
    chk("rst_rsp_valid", tmr_rsp_valid, 0);
    repeat (5) @(posedge clk); #1;
    bus(0, 5'h00, 0, r, e); chk("rst_mtime_lo", r, 0); chk("rst_err", e, 0);
    bus(0, 5'h0C, 0, r, e); chk("rst_cmp_hi", r, 32'hFFFF_FFFF);
    // compare at 0x10, count every cycle: irq 17 cycles after the enabling write
    bus(1, 5'h08, 32'h10, r, e);
    bus(1, 5'h0C, 32'h0, r, e);
    chk("irq_before_en", tmr_irq_r, 0);
    bus(1, 5'h10, 32'h1, r, e); chk("wr_rdat_zero", r, 0);
    for (int i = 0; i < 100 && !tmr_irq_r; i++) begin
      @(posedge clk); #1;
    end
    chk("irq_latency", 64'(cyc - acc_cyc), 17);
    bus(1, 5'h0C, 32'hFFFF_FFFF, r, e);
    chk("irq_fall", tmr_irq_r, 0);
    bus(0, 5'h18, 0, r, e); chk("unmapped_rdat", r, 0); chk("unmapped_err", e, 1);
    bus(1, 5'h1C, 32'h5, r, e); chk("unmapped_wr_err", e, 1);
    // div=3: one increment per 4 cycles
    bus(1, 5'h10, 32'h0, r, e);
    bus(1, 5'h00, 32'h0, r, e);
    bus(1, 5'h04, 32'h0, r, e);
    bus(1, 5'h10, 32'h7, r, e);
    repeat (19) @(posedge clk); #1;
    bus(0, 5'h00, 0, r, e); chk("div3_mtime", r, 5);
    bus(0, 5'h10, 0, r, e); chk("ctrl_rd", r, 7);
    // carry from lo into hi
    bus(1, 5'h10, 32'h0, r, e);
    bus(1, 5'h00, 32'hFFFF_FFFF, r, e);
    bus(1, 5'h04, 32'h0, r, e);
    bus(1, 5'h10, 32'h1, r, e);
    bus(0, 5'h00, 0, r, e); chk("carry_lo", r, 0);
    repeat (3) @(posedge clk); #1;
    bus(0, 5'h04, 0, r, e); chk("carry_hi_snap", r, 1);
    // write on a tick cycle: written half wins, no increment that cycle
    bus(1, 5'h00, 32'h100, r, e);
    bus(0, 5'h00, 0, r, e); chk("wr_on_tick_lo", r, 32'h101);
    bus(0, 5'h04, 0, r, e); chk("wr_on_tick_hi", r, 1);
    // response backpressure; a second request must wait
    tmr_rsp_ready = 1'b0;
    tmr_req_valid = 1'b1; tmr_req_wr = 1'b0; tmr_req_addr = 5'h08;
    @(posedge clk); #1;
    tmr_req_addr = 5'h0C;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", tmr_rsp_valid, 1);
      chk("bp_ready", tmr_req_ready, 0);
      chk("bp_rdat", tmr_rsp_rdat, 32'h10);
      @(posedge clk); #1;
    end
    tmr_rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", tmr_rsp_valid, 0);
    @(posedge clk); #1;
    chk("bp_second_valid", tmr_rsp_valid, 1);
    chk("bp_second_rdat", tmr_rsp_rdat, 32'hFFFF_FFFF);
    tmr_req_valid = 1'b0;
    @(posedge clk); #1;
    // async reset drops a pending response
    tmr_rsp_ready = 1'b0;
    bus(0, 5'h10, 0, r, e);
    chk("pend_valid", tmr_rsp_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_valid", tmr_rsp_valid, 0);
    chk("rst_mid_ready", tmr_req_ready, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    tmr_rsp_ready = 1'b1;
    bus(0, 5'h10, 0, r, e); chk("rst2_ctrl", r, 0);
    bus(0, 5'h08, 0, r, e); chk("rst2_cmp_lo", r, 32'hFFFF_FFFF);
    bus(0, 5'h00, 0, r, e); chk("rst2_mtime", r, 0);
    repeat (2) @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
